ahb_delay_sched: RTL

Programmable delay scheduler for the AHB delay FIFO. It owns the `counter_num0` delay-count input of the FIFO and chooses a delay value per bus transaction. The value is either zero (FIFO bypass), a fixed count, a pseudo-random count or a ramp. A small register port configures it. The block sits beside the FIFO on the `cpu_clk` domain, between the smart_run testbench configuration logic and the FIFO.

---
 rtl/ahb_delay_pkg.sv | 24 ++
 rtl/ahb_delay_lfsr.sv | 32 +++
 rtl/ahb_delay_sched.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/ahb_delay_pkg.sv
// Shared encodings for the AHB delay scheduler: modes, register map, LFSR taps and seed.
package ahb_delay_pkg;

    typedef enum logic [1:0] {
        ModeOff    = 2'd0,
        ModeFixed  = 2'd1,
        ModeRandom = 2'd2,
        ModeRamp   = 2'd3
    } mode_e;

    localparam logic [1:0] RegCtrl = 2'd0;
    localparam logic [1:0] RegBase = 2'd1;
    localparam logic [1:0] RegMask = 2'd2;
    localparam logic [1:0] RegStat = 2'd3;

    // x^16 + x^14 + x^13 + x^11 + 1, bit positions of a left-shifting register
    localparam int unsigned LfsrTapA = 15;
    localparam int unsigned LfsrTapB = 13;
    localparam int unsigned LfsrTapC = 12;
    localparam int unsigned LfsrTapD = 10;

    localparam logic [15:0] DefaultSeed = 16'hACE1;

endpackage

// File: rtl/ahb_delay_lfsr.sv
// 16-bit Fibonacci LFSR; exposes the value it will hold after the current cycle.
module ahb_delay_lfsr
    import ahb_delay_pkg::*;
#(
    parameter logic [15:0] SEED = DefaultSeed
) (
    input  logic        cpu_clk,
    input  logic        cpu_rst,
    input  logic        en,
    output logic [15:0] lfsr_nxt
);

    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;
    logic        fb;

    always_comb begin
        fb     = lfsr_q[LfsrTapA] ^ lfsr_q[LfsrTapB] ^ lfsr_q[LfsrTapC] ^ lfsr_q[LfsrTapD];
        lfsr_d = en ? {lfsr_q[14:0], fb} : lfsr_q;
    end

    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign lfsr_nxt = lfsr_d;

endmodule

// File: rtl/ahb_delay_sched.sv
// Delay scheduler: picks the FIFO delay count per accepted AHB transaction from a
// shadowed register set that only takes effect on a quiet bus cycle.
module ahb_delay_sched
    import ahb_delay_pkg::*;
#(
    parameter logic [15:0] SEED  = DefaultSeed,
    parameter int unsigned CNT_W = 32
) (
    input  logic             cpu_clk,
    input  logic             cpu_rst,
    input  logic [1:0]       biu_pad_htrans,
    input  logic             fifo_biu_hready,
    input  logic             cfg_wr,
    input  logic [1:0]       cfg_addr,
    input  logic [31:0]      cfg_wdata,
    output logic [31:0]      cfg_rdata,
    output logic             cfg_pending,
    output logic [CNT_W-1:0] counter_num0
);

    mode_e             sh_mode_q, sh_mode_d, act_mode_q, act_mode_d;
    logic [CNT_W-1:0]  sh_base_q, sh_base_d, act_base_q, act_base_d;
    logic [15:0]       sh_mask_q, sh_mask_d, act_mask_q, act_mask_d;
    logic              pending_q, pending_d;
    logic [15:0]       ramp_q, ramp_d;
    logic [CNT_W-1:0]  stat_q, stat_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  nxt;
    logic [15:0]       lfsr_nxt;
    logic              acc, quiet, commit, wr_shadow, wr_stat, lfsr_en;
    logic              unused_htrans0;

    assign unused_htrans0 = biu_pad_htrans[0];

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                 input logic [15:0] b);
        logic [CNT_W:0] s;
        s = {1'b0, a} + {{(CNT_W - 15){1'b0}}, b};
        return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
    endfunction

    assign acc       = biu_pad_htrans[1] && fifo_biu_hready;
    assign quiet     = fifo_biu_hready && !biu_pad_htrans[1];
    assign commit    = quiet && pending_q;
    assign wr_stat   = cfg_wr && (cfg_addr == RegStat);
    assign wr_shadow = cfg_wr && (cfg_addr != RegStat);
    assign lfsr_en   = acc && (act_mode_q == ModeRandom);

    ahb_delay_lfsr #(
        .SEED (SEED)
    ) u_lfsr (
        .cpu_clk  (cpu_clk),
        .cpu_rst  (cpu_rst),
        .en       (lfsr_en),
        .lfsr_nxt (lfsr_nxt)
    );

    always_comb begin
        sh_mode_d = sh_mode_q;
        sh_base_d = sh_base_q;
        sh_mask_d = sh_mask_q;
        if (cfg_wr) begin
            unique case (cfg_addr)
                RegCtrl: sh_mode_d = mode_e'(cfg_wdata[1:0]);
                RegBase: sh_base_d = CNT_W'(cfg_wdata);
                RegMask: sh_mask_d = cfg_wdata[15:0];
                default: ;
            endcase
        end

        // Commit copies the pre-write shadow; a coincident write keeps pending set
        act_mode_d = commit ? sh_mode_q : act_mode_q;
        act_base_d = commit ? sh_base_q : act_base_q;
        act_mask_d = commit ? sh_mask_q : act_mask_q;
        pending_d  = wr_shadow ? 1'b1 : (commit ? 1'b0 : pending_q);

        ramp_d = ramp_q;
        if (commit) begin
            ramp_d = '0;
        end else if (acc && (act_mode_q == ModeRamp)) begin
            ramp_d = (ramp_q == act_mask_q) ? 16'd0 : ramp_q + 16'd1;
        end

        stat_d = stat_q;
        if (wr_stat) begin
            stat_d = '0;
        end else if (acc && (act_mode_q != ModeOff) && (stat_q != {CNT_W{1'b1}})) begin
            stat_d = stat_q + 1'b1;
        end

        nxt = '0;
        unique case (act_mode_d)
            ModeOff:    nxt = '0;
            ModeFixed:  nxt = act_base_d;
            ModeRandom: nxt = sat_add(act_base_d, lfsr_nxt & act_mask_d);
            ModeRamp:   nxt = sat_add(act_base_d, ramp_d);
            default:    nxt = '0;
        endcase

        cnt_d = (acc || commit) ? nxt : cnt_q;
    end

    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            sh_mode_q  <= ModeOff;
            sh_base_q  <= '0;
            sh_mask_q  <= '0;
            act_mode_q <= ModeOff;
            act_base_q <= '0;
            act_mask_q <= '0;
            pending_q  <= 1'b0;
            ramp_q     <= '0;
            stat_q     <= '0;
            cnt_q      <= '0;
        end else begin
            sh_mode_q  <= sh_mode_d;
            sh_base_q  <= sh_base_d;
            sh_mask_q  <= sh_mask_d;
            act_mode_q <= act_mode_d;
            act_base_q <= act_base_d;
            act_mask_q <= act_mask_d;
            pending_q  <= pending_d;
            ramp_q     <= ramp_d;
            stat_q     <= stat_d;
            cnt_q      <= cnt_d;
        end
    end

    always_comb begin
        cfg_rdata = '0;
        unique case (cfg_addr)
            RegCtrl: cfg_rdata = {30'd0, sh_mode_q};
            RegBase: cfg_rdata = 32'(sh_base_q);
            RegMask: cfg_rdata = {16'd0, sh_mask_q};
            RegStat: cfg_rdata = 32'(stat_q);
            default: cfg_rdata = '0;
        endcase
    end

    assign cfg_pending  = pending_q;
    assign counter_num0 = cnt_q;

endmodule
